hdmi_frame_checker: RTL
=======================

Name: hdmi_frame_checker

Overview:
- Synthesizable, parametrised frame monitor. It sits on the pixel-domain video bus next to the HDMI source: at the inputs of the TMDS encoder, or at the outputs of a loopback decoder.
- Checks geometry and frame-to-frame stability of N colour channels.
- Publishes per-frame checksums, a frame counter, sticky error flags and a done flag. Simulation benches and on-board LED self-test both use it to confirm that a target number of good frames were generated.

Parameters:
- NUM_CHANNELS, 3, number of colour channels monitored.
- BIT_WIDTH, 8, bits per channel sample.
- H_ACTIVE, 640, required DE-high run length per line, in pixels.
- V_ACTIVE, 480, required count of active lines per frame.
- CHECKSUM_WIDTH, 16, per-channel checksum width (must be >= BIT_WIDTH).
- FRAME_TARGET, 3, completed-frame count at which done asserts.
- COUNT_WIDTH, 8, width of frame_count.
- VSYNC_ACTIVE, 1'b1, asserted level of vsync.

Ports:
- CLK  input  1  pixel clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-low.
- vsync  input  1  vertical sync, asserted level = VSYNC_ACTIVE.
- de  input  1  data enable (active video).
- data  input  NUM_CHANNELS*BIT_WIDTH  pixel samples; channel k occupies bits [k*BIT_WIDTH +: BIT_WIDTH].
- frame_valid  output  1  one-cycle pulse when a frame completes.
- checksum  output  NUM_CHANNELS*CHECKSUM_WIDTH  checksums of the last completed frame.
- frame_count  output  COUNT_WIDTH  completed frames, saturating.
- geometry_error  output  1  sticky geometry violation.
- checksum_mismatch  output  1  sticky frame-to-frame difference.
- done  output  1  sticky; frame_count >= FRAME_TARGET.

Behaviour:
Reset
- Reset: RST low at a rising CLK edge.
- All outputs and internal state go to 0. FSM enters WAIT_SYNC.

Frame boundary
- Boundary = the cycle where vsync is asserted and vsync was deasserted on the previous cycle (registered edge detect).

FSM
- WAIT_SYNC: ignore de/data. On a boundary, clear the accumulators and go to IN_FRAME. Any partial frame after reset is discarded.
- IN_FRAME: accumulate. On the next boundary, close the frame and stay in IN_FRAME.

Accumulation (IN_FRAME, de=1)
- Per channel: chk_k <= rotl1(chk_k) ^ zero_extend(sample_k).
- run_len increments, saturating at H_ACTIVE+1.

Line close
- A line closes on the de 1->0 edge.
- geometry_error sets if run_len != H_ACTIVE.
- line_cnt increments, saturating at V_ACTIVE+1. run_len clears.

Frame close, same cycle as the boundary
- If de=1 on the boundary cycle: geometry_error sets (truncated line).
- If line_cnt != V_ACTIVE: geometry_error sets.
- checksum <= accumulators. frame_valid = 1 for exactly that cycle.
- frame_count increments, saturating at all-ones.
- If at least one frame was already published and new checksum != previous checksum: checksum_mismatch sets.

Accumulator restart
- Accumulators, line_cnt and run_len restart on the boundary cycle.
- A pixel presented with de=1 on the boundary cycle belongs to the new frame: accumulation starts from 0.

Output timing
- done = registered (frame_count >= FRAME_TARGET); rises the cycle after the frame_valid that reaches the target.
- All outputs are registered. Latency: boundary edge cycle -> frame_valid/checksum/frame_count update on the next CLK edge.

Flags
- Sticky flags clear only on reset.
- Monitoring continues after done; done stays high.

Test Plan:
Parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, NUM_CHANNELS=3, CHECKSUM_WIDTH=16, FRAME_TARGET=3.
1. Clean frames: reset, then 4 vsync boundaries bounding 3 frames of 2 lines x 4 pixels, ch0=0x01, ch1=0x00, ch2=0x80 -> 3 frame_valid pulses; ch0 checksum 0x00FF, ch1 0x0000, ch2 0x7F80; frame_count=3; done=1; both error flags 0.
2. Short line: frame 1 line 2 carries 3 pixels -> geometry_error=1 after that de falling edge; frame_valid still pulses; checksum_mismatch unaffected.
3. Changed pixel: frame 2 pixel (1,2) ch1=0x05, others as in scenario 1 -> checksum_mismatch=1 at frame 2 close; geometry_error=0.
4. Mid-frame reset: RST low for 1 cycle mid-line of frame 2 -> all outputs 0 next cycle; frames before the next boundary are ignored; counting restarts at 1 on the second subsequent boundary.
5. Boundary collision: de=1 on the vsync edge cycle -> geometry_error=1; that pixel is accumulated into the new frame; frame_count still increments.
6. Saturation: COUNT_WIDTH=2, 5 clean frames -> frame_count holds 3; done stays 1; no flags set.

Source files
------------

// File: rtl/hdmi_frame_checker.sv
// Pixel-domain frame monitor: checks active-video geometry and frame-to-frame
// checksum stability of NUM_CHANNELS colour channels, publishing per-frame results.
module hdmi_frame_checker #(
  parameter int unsigned NUM_CHANNELS   = 3,
  parameter int unsigned BIT_WIDTH      = 8,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned CHECKSUM_WIDTH = 16,
  parameter int unsigned FRAME_TARGET   = 3,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter logic        VSYNC_ACTIVE   = 1'b1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   vsync,
  input  logic                                   de,
  input  logic [NUM_CHANNELS*BIT_WIDTH-1:0]      data,
  output logic                                   frame_valid,
  output logic [NUM_CHANNELS*CHECKSUM_WIDTH-1:0] checksum,
  output logic [COUNT_WIDTH-1:0]                 frame_count,
  output logic                                   geometry_error,
  output logic                                   checksum_mismatch,
  output logic                                   done
);

  localparam int unsigned RUN_W  = $clog2(H_ACTIVE + 2);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 2);
  localparam int unsigned ACC_W  = NUM_CHANNELS * CHECKSUM_WIDTH;

  localparam logic [RUN_W-1:0]  RUN_TGT  = RUN_W'(H_ACTIVE);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(H_ACTIVE + 1);
  localparam logic [LINE_W-1:0] LINE_TGT = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE + 1);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    IN_FRAME  = 1'b1
  } state_t;

  state_t                   r_state;
  logic                     r_vs_prev;
  logic                     r_de_d;
  logic [ACC_W-1:0]         r_acc;
  logic [RUN_W-1:0]         r_run_len;
  logic [LINE_W-1:0]        r_line_cnt;
  logic                     r_published;
  logic                     r_frame_valid;
  logic [ACC_W-1:0]         r_checksum;
  logic [COUNT_WIDTH-1:0]   r_frame_count;
  logic                     r_geometry_error;
  logic                     r_checksum_mismatch;
  logic                     r_done;

  logic                     w_vs_act;
  logic                     w_boundary;
  logic                     w_line_close;
  logic                     w_line_bad;
  logic [LINE_W-1:0]        w_line_cnt_eff;
  logic [ACC_W-1:0]         w_pix_acc;
  logic [ACC_W-1:0]         w_pix_new;
  logic [CHECKSUM_WIDTH-1:0] w_cur;
  logic [CHECKSUM_WIDTH-1:0] w_smp;

  assign w_vs_act     = (vsync == VSYNC_ACTIVE);
  assign w_boundary   = w_vs_act & ~r_vs_prev;
  assign w_line_close = r_de_d & ~de;
  assign w_line_bad   = w_line_close & (r_run_len != RUN_TGT);

  // A line ending on the boundary cycle still counts toward the closing frame.
  always_comb begin
    w_line_cnt_eff = r_line_cnt;
    if (w_line_close && (r_line_cnt != LINE_MAX)) begin
      w_line_cnt_eff = r_line_cnt + 1'b1;
    end
  end

  always_comb begin
    w_pix_acc = '0;
    w_pix_new = '0;
    w_cur     = '0;
    w_smp     = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_cur = r_acc[k*CHECKSUM_WIDTH +: CHECKSUM_WIDTH];
      w_smp = CHECKSUM_WIDTH'(data[k*BIT_WIDTH +: BIT_WIDTH]);
      w_pix_acc[k*CHECKSUM_WIDTH +: CHECKSUM_WIDTH] =
        {w_cur[CHECKSUM_WIDTH-2:0], w_cur[CHECKSUM_WIDTH-1]} ^ w_smp;
      w_pix_new[k*CHECKSUM_WIDTH +: CHECKSUM_WIDTH] = w_smp;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state             <= WAIT_SYNC;
      r_vs_prev           <= 1'b0;
      r_de_d              <= 1'b0;
      r_acc               <= '0;
      r_run_len           <= '0;
      r_line_cnt          <= '0;
      r_published         <= 1'b0;
      r_frame_valid       <= 1'b0;
      r_checksum          <= '0;
      r_frame_count       <= '0;
      r_geometry_error    <= 1'b0;
      r_checksum_mismatch <= 1'b0;
      r_done              <= 1'b0;
    end else begin
      r_vs_prev     <= w_vs_act;
      r_de_d        <= de;
      r_frame_valid <= 1'b0;
      r_done        <= r_done | (32'(r_frame_count) >= FRAME_TARGET);

      case (r_state)
        WAIT_SYNC: begin
          if (w_boundary) begin
            r_state    <= IN_FRAME;
            r_acc      <= de ? w_pix_new : '0;
            r_run_len  <= de ? RUN_W'(1) : '0;
            r_line_cnt <= '0;
          end
        end

        IN_FRAME: begin
          if (w_boundary) begin
            // Close the finished frame; a pixel on this cycle opens the next one.
            if (de || w_line_bad || (w_line_cnt_eff != LINE_TGT)) begin
              r_geometry_error <= 1'b1;
            end
            r_checksum    <= r_acc;
            r_frame_valid <= 1'b1;
            if (r_frame_count != '1) begin
              r_frame_count <= r_frame_count + 1'b1;
            end
            if (r_published && (r_acc != r_checksum)) begin
              r_checksum_mismatch <= 1'b1;
            end
            r_published <= 1'b1;
            r_acc       <= de ? w_pix_new : '0;
            r_run_len   <= de ? RUN_W'(1) : '0;
            r_line_cnt  <= '0;
          end else begin
            if (de) begin
              r_acc <= w_pix_acc;
              if (r_run_len != RUN_MAX) begin
                r_run_len <= r_run_len + 1'b1;
              end
            end
            if (w_line_close) begin
              if (w_line_bad) begin
                r_geometry_error <= 1'b1;
              end
              r_line_cnt <= w_line_cnt_eff;
              r_run_len  <= '0;
            end
          end
        end

        default: r_state <= WAIT_SYNC;
      endcase
    end
  end

  assign frame_valid       = r_frame_valid;
  assign checksum          = r_checksum;
  assign frame_count       = r_frame_count;
  assign geometry_error    = r_geometry_error;
  assign checksum_mismatch = r_checksum_mismatch;
  assign done              = r_done;

endmodule
